// File: rtl/argmax_unit_pkg.sv
// argmax_unit_pkg
//   Shared definitions for the argmax classifier slice: default sizing
//   parameters and the controller state enumeration. Imported by
//   argmax_cmp and argmax_unit.
package argmax_unit_pkg;

    // Default number of scores in one classification.
    localparam int ARGMAX_N_CLASSES = 10;

    // Default score width (two's-complement signed).
    localparam int ARGMAX_DATA_W    = 8;

    // Default index / beat-counter width; 2**ARGMAX_IDX_W >= ARGMAX_N_CLASSES.
    localparam int ARGMAX_IDX_W     = 4;

    // Controller states.
    //   IDLE : waiting for a start pulse
    //   SCAN : accepting scores, one per in_valid/in_ready handshake
    //   DONE : presenting the result until the consumer takes it
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } argmax_state_t;

endpackage : argmax_unit_pkg

// File: rtl/argmax_cmp.sv
// argmax_cmp
//   Purely combinational signed compare-and-select for the argmax scan.
//   Decides whether the incoming score replaces the running maximum and
//   produces the selected (score, index) pair.
//
// Ports
//   first    in   1       incoming score is beat 0: always taken
//   in_data  in   DATA_W  incoming signed score
//   in_idx   in   IDX_W   class index of the incoming score
//   cur_max  in   DATA_W  running maximum score (signed)
//   cur_idx  in   IDX_W   class index of the running maximum
//   take     out  1       incoming score replaces the running maximum
//   sel_max  out  DATA_W  selected score
//   sel_idx  out  IDX_W   selected index
module argmax_cmp
    import argmax_unit_pkg::*;
#(
    parameter int DATA_W = ARGMAX_DATA_W,
    parameter int IDX_W  = ARGMAX_IDX_W
) (
    input  logic              first,
    input  logic [DATA_W-1:0] in_data,
    input  logic [IDX_W-1:0]  in_idx,
    input  logic [DATA_W-1:0] cur_max,
    input  logic [IDX_W-1:0]  cur_idx,
    output logic              take,
    output logic [DATA_W-1:0] sel_max,
    output logic [IDX_W-1:0]  sel_idx
);

    logic greater;

    // Strictly greater: an equal later score never displaces an earlier
    // one, so ties resolve to the lowest class index.
    always_comb begin
        greater = $signed(in_data) > $signed(cur_max);
        take    = first | greater;
        sel_max = take ? in_data : cur_max;
        sel_idx = take ? in_idx  : cur_idx;
    end

endmodule : argmax_cmp

// File: rtl/argmax_unit.sv
// argmax_unit
//   Streams N_CLASSES signed scores (class order 0..N_CLASSES-1) after a
//   start pulse and reports the index and value of the largest one.
//   Ties resolve to the lowest index. The result appears one cycle after
//   the last accepted score and is held until the consumer handshakes.
//
// Ports
//   clk        in   1       clock, rising edge
//   rst_n      in   1       synchronous active-low reset
//   start      in   1       opens a new classification (honoured in IDLE only)
//   in_valid   in   1       in_data holds a valid score
//   in_ready   out  1       a score is accepted this cycle when in_valid is high
//   in_data    in   DATA_W  signed score
//   out_valid  out  1       result valid
//   out_ready  in   1       consumer accepts the result
//   out_idx    out  IDX_W   winning class index (registered)
//   out_max    out  DATA_W  winning score (registered)
//   busy       out  1       block is not IDLE
module argmax_unit
    import argmax_unit_pkg::*;
#(
    parameter int N_CLASSES = ARGMAX_N_CLASSES,
    parameter int DATA_W    = ARGMAX_DATA_W,
    parameter int IDX_W     = ARGMAX_IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_max,
    output logic              busy
);

    // Index of the final beat; the counter stops here rather than wrapping.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

    argmax_state_t     state;
    argmax_state_t     state_next;

    logic [IDX_W-1:0]  count;
    logic [IDX_W-1:0]  count_next;

    logic [DATA_W-1:0] max_reg;
    logic [IDX_W-1:0]  idx_reg;

    logic              beat_acc;
    logic              last_beat;
    logic              first_beat;

    logic              cmp_take;
    logic [DATA_W-1:0] cmp_max;
    logic [IDX_W-1:0]  cmp_idx;

    // ------------------------------------------------------------------
    // Compare-and-select against the running maximum
    // ------------------------------------------------------------------
    argmax_cmp #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_cmp (
        .first   (first_beat),
        .in_data (in_data),
        .in_idx  (count),
        .cur_max (max_reg),
        .cur_idx (idx_reg),
        .take    (cmp_take),
        .sel_max (cmp_max),
        .sel_idx (cmp_idx)
    );

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        in_ready   = (state == SCAN);
        out_valid  = (state == DONE);
        busy       = (state != IDLE);
        beat_acc   = in_ready & in_valid;
        first_beat = (count == '0);
        last_beat  = (count == LAST_IDX);
    end

    // ------------------------------------------------------------------
    // Controller: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // ------------------------------------------------------------------
    // Controller: next state and beat counter
    // start is only looked at in IDLE, so it cannot restart or abort a scan
    // or a pending result.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        count_next = count;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = SCAN;
                    count_next = '0;
                end
            end

            SCAN: begin
                if (beat_acc) begin
                    if (last_beat) begin
                        state_next = DONE;
                    end else begin
                        count_next = count + IDX_W'(1);
                    end
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Result registers: updated only on accepted beats, so they hold
    // steady through DONE and drive the outputs directly.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_reg <= '0;
            idx_reg <= '0;
        end else if (beat_acc && cmp_take) begin
            max_reg <= cmp_max;
            idx_reg <= cmp_idx;
        end
    end

    always_comb begin
        out_idx = idx_reg;
        out_max = max_reg;
    end

endmodule : argmax_unit

// File: tb/tb_argmax_unit.sv
module tb_argmax_unit;

    localparam int N  = 10;
    localparam int DW = 8;
    localparam int IW = 4;

    typedef int vec_t [N];

    typedef struct {
        vec_t  s;
        int    eidx;
        int    emax;
        int    mode;      // 0: back-to-back, 1: random gaps, 2: valid 1,0,0,...
        int    hold;      // cycles out_ready stays low in DONE
        bit    rdy_early; // out_ready already high on DONE entry
        bit    start_mid; // pulse start during the scan
        string tag;
    } vrec_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_idx;
    logic [DW-1:0] out_max;
    logic          busy;

    int total = 0;
    int bad   = 0;

    argmax_unit #(
        .N_CLASSES (N),
        .DATA_W    (DW),
        .IDX_W     (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_max   (out_max),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: act=%0d req=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the maximum value first, then the lowest index holding it.
    task automatic ref_argmax(input vec_t s, output int idx, output int mx);
        mx = s[0];
        foreach (s[i]) if (s[i] > mx) mx = s[i];
        idx = -1;
        foreach (s[i]) if (idx < 0 && s[i] == mx) idx = i;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"},  int'(in_ready),  0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_idx"},   int'(out_idx),   0);
        chk({tag, "_out_max"},   int'(out_max),   0);
        chk({tag, "_busy"},      int'(busy),      0);
    endtask

    // Feeds beats [0, upto) of s; returns with the DUT one cycle after the last beat.
    task automatic feed(input vec_t s, input int upto, input int mode, input bit start_mid,
                        input string tag);
        int   beat = 0;
        int   cyc  = 0;
        logic v;
        while (beat < upto && cyc < 200) begin
            chk({tag, "_in_ready_scan"}, int'(in_ready), 1);
            case (mode)
                0:       v = 1'b1;
                1:       v = 1'($urandom_range(0, 1));
                default: v = (cyc % 3 == 0);
            endcase
            in_valid = v;
            in_data  = v ? DW'(s[beat]) : DW'($urandom);
            start    = start_mid && (beat == 5);
            @(negedge clk);
            if (v) beat++;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (beat < upto) chk({tag, "_scan_timeout"}, beat, upto);
    endtask

    task automatic run_vec(input vrec_t r);
        @(negedge clk);
        start     = 1'b1;
        out_ready = r.rdy_early;
        @(negedge clk);
        start = 1'b0;
        chk({r.tag, "_busy_scan"}, int'(busy), 1);
        feed(r.s, N, r.mode, r.start_mid, r.tag);
        // one cycle after the final beat
        chk({r.tag, "_out_valid"},     int'(out_valid),        1);
        chk({r.tag, "_in_ready_done"}, int'(in_ready),         0);
        chk({r.tag, "_out_idx"},       int'(out_idx),          r.eidx);
        chk({r.tag, "_out_max"},       int'($signed(out_max)), r.emax);
        if (!r.rdy_early) begin
            for (int h = 0; h < r.hold; h++) begin
                in_valid = 1'b1;
                in_data  = 8'h7F;
                start    = (h == 1);
                @(negedge clk);
                chk({r.tag, "_hold_valid"}, int'(out_valid),        1);
                chk({r.tag, "_hold_idx"},   int'(out_idx),          r.eidx);
                chk({r.tag, "_hold_max"},   int'($signed(out_max)), r.emax);
            end
            in_valid  = 1'b0;
            start     = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk({r.tag, "_after_valid"}, int'(out_valid), 0);
        chk({r.tag, "_after_busy"},  int'(busy),      0);
        chk({r.tag, "_after_ready"}, int'(in_ready),  0);
    endtask

    vrec_t tbl [$];
    vrec_t r;
    vec_t  v;
    int    ei, em;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        out_ready = 1'b1;
        // reset wins over start/in_valid/out_ready
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        chk_all_zero("idle");

        r = '{s: '{3, -5, 17, 2, 9, 0, -1, 16, 4, 8}, eidx: 2, emax: 17, mode: 0,
              hold: 2, rdy_early: 1'b0, start_mid: 1'b0, tag: "basic"};
        tbl.push_back(r);
        r = '{s: '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128}, eidx: 0,
              emax: -128, mode: 0, hold: 1, rdy_early: 1'b0, start_mid: 1'b0, tag: "allmin"};
        tbl.push_back(r);
        r = '{s: '{5, 7, 7, 1, 0, 0, 0, 0, 0, 0}, eidx: 1, emax: 7, mode: 0,
              hold: 0, rdy_early: 1'b1, start_mid: 1'b0, tag: "tie"};
        tbl.push_back(r);
        r = '{s: '{-1, -2, -128, -50, -3, -100, -7, -9, -127, 127}, eidx: 9, emax: 127, mode: 0,
              hold: 0, rdy_early: 1'b0, start_mid: 1'b0, tag: "lastmax"};
        tbl.push_back(r);
        r = '{s: '{4, 1, 20, 3, 30, 2, 30, 8, -6, 12}, eidx: 4, emax: 30, mode: 2,
              hold: 5, rdy_early: 1'b0, start_mid: 1'b1, tag: "gaps"};
        tbl.push_back(r);
        r = '{s: '{127, 127, 0, 0, 0, 0, 0, 0, 0, 127}, eidx: 0, emax: 127, mode: 1,
              hold: 1, rdy_early: 1'b1, start_mid: 1'b0, tag: "allmax"};
        tbl.push_back(r);

        foreach (tbl[k]) run_vec(tbl[k]);

        // reset after beat 4 discards the partial result
        v = '{10, 20, 120, 30, 40, 0, 0, 0, 0, 0};
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        feed(v, 5, 0, 1'b0, "rst_scan");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_all_zero("rst_scan");
        r = '{s: '{-9, -3, -8, -3, -20, -4, -5, -60, -7, -10}, eidx: 1, emax: -3, mode: 0,
              hold: 1, rdy_early: 1'b0, start_mid: 1'b0, tag: "post_rst"};
        run_vec(r);

        // reset in DONE discards the pending result
        v = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 100};
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        feed(v, N, 0, 1'b0, "rst_done");
        chk("rst_done_pre_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_all_zero("rst_done");

        // randomized vectors against the reference model
        for (int t = 0; t < 30; t++) begin
            foreach (v[i]) begin
                case ($urandom_range(0, 3))
                    0:       v[i] = int'($signed(DW'($urandom)));
                    1:       v[i] = $urandom_range(0, 3) - 2;
                    2:       v[i] = ($urandom_range(0, 1) != 0) ? 127 : -128;
                    default: v[i] = int'($urandom_range(0, 40)) - 20;
                endcase
            end
            ref_argmax(v, ei, em);
            r.s         = v;
            r.eidx      = ei;
            r.emax      = em;
            r.mode      = $urandom_range(0, 2);
            r.hold      = $urandom_range(0, 4);
            r.rdy_early = 1'($urandom_range(0, 1));
            r.start_mid = 1'($urandom_range(0, 1));
            r.tag       = $sformatf("rnd%0d", t);
            run_vec(r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_argmax_unit

// File: doc/argmax_unit.md
ARGMAX_UNIT -- requirements
Module: argmax_unit

Interface
REQ-001 Parameter: N_CLASSES, 10, number of scores per classification.
REQ-002 Parameter: DATA_W, 8, score width, two's-complement signed.
REQ-003 Parameter: IDX_W, 4, index width; SHALL satisfy 2**IDX_W >= N_CLASSES.
REQ-004 Port: clk  input  1  single clock; all logic on rising edge.
REQ-005 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-006 Port: start  input  1  one-cycle pulse opening a new classification.
REQ-007 Port: in_valid  input  1  in_data holds a valid score.
REQ-008 Port: in_ready  output  1  block accepts a score this cycle.
REQ-009 Port: in_data  input  DATA_W  signed score, class order 0..N_CLASSES-1.
REQ-010 Port: out_valid  output  1  result valid.
REQ-011 Port: out_ready  input  1  consumer accepts result.
REQ-012 Port: out_idx  output  IDX_W  winning class index (predicted label).
REQ-013 Port: out_max  output  DATA_W  winning score.
REQ-014 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-015 States: IDLE, SCAN, DONE; encoding from the shared package.
REQ-016 IDLE: in_ready=0, out_valid=0; start=1 -> SCAN, beat counter cleared to 0.
REQ-017 start SHALL be ignored in SCAN and DONE; it neither restarts nor aborts.
REQ-018 SCAN: in_ready=1; a beat is accepted when in_valid and in_ready are both high; no acceptance otherwise, state held.
REQ-019 First accepted beat (count 0) loads max_reg=in_data, idx_reg=0 unconditionally.
REQ-020 Later beats: if in_data > max_reg (signed, strict), load max_reg=in_data, idx_reg=count; otherwise hold.
REQ-021 Ties: lowest index wins; equal later scores never replace.
REQ-022 Accepting beat N_CLASSES-1 -> DONE on the next edge; out_valid asserts the cycle after the last beat (1-cycle latency).
REQ-023 DONE: in_ready=0; out_valid=1; out_idx/out_max stable until out_valid and out_ready are both high, then -> IDLE.
REQ-024 out_ready already high on DONE entry: result held exactly one cycle, then IDLE.
REQ-025 Beat counter width IDX_W; terminal value N_CLASSES-1, no wrap beyond it.
REQ-026 Comparison SHALL use DATA_W-bit signed arithmetic; 8'h80 (-128) is the minimum, 8'h7F (+127) the maximum.
REQ-027 out_idx and out_max SHALL be driven directly by registers, not combinationally from in_data.

Reset
REQ-028 rst_n=0 at a clock edge: state=IDLE, count=0, max_reg=0, idx_reg=0; outputs in_ready=0, out_valid=0, out_idx=0, out_max=0, busy=0.
REQ-029 Reset asserted mid-SCAN or mid-DONE SHALL discard the partial or pending result with no output handshake.
REQ-030 rst_n has priority over start, in_valid and out_ready in the same cycle.

Structure
REQ-031 Shared package holds the state enumeration, DATA_W/IDX_W defaults and the N_CLASSES default.
REQ-032 The signed compare-and-select (score, index vs. current max) SHALL be one sub-module, argmax_cmp, purely combinational; the FSM, counter and registers stay in argmax_unit.

Verification
REQ-033 Scores 3,-5,17,2,9,0,-1,16,4,8 back-to-back -> out_idx=2, out_max=17, out_valid on the cycle after beat 9.
REQ-034 All ten scores 8'h80 -> out_idx=0, out_max=-128; scores 5,7,7,1,... -> out_idx=1 (tie rule).
REQ-035 Last score +127 with all others negative -> out_idx=9, out_max=127 (signed compare, terminal beat).
REQ-036 in_valid toggled 1,0,0,1,... and out_ready held low 5 cycles -> result unchanged, out_valid held, no extra beats accepted; start pulsed mid-SCAN -> ignored.
REQ-037 rst_n low after beat 4 -> all outputs 0, state IDLE next cycle; new start then full vector -> correct result unaffected by old data.
